// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display blocks: segment bit positions,
// the active-low hex font table and the scan FSM state type.
package seg7_pkg;

   // Segment bus layout {a,b,c,d,e,f,g,dp}
   localparam int unsigned SEG_A  = 7;
   localparam int unsigned SEG_B  = 6;
   localparam int unsigned SEG_C  = 5;
   localparam int unsigned SEG_D  = 4;
   localparam int unsigned SEG_E  = 3;
   localparam int unsigned SEG_F  = 2;
   localparam int unsigned SEG_G  = 1;
   localparam int unsigned SEG_DP = 0;

   // Active-low codes with dp off; element 0 is the glyph for hex 0
   localparam logic [15:0][7:0] SEG_FONT = {
      8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
      8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
   };

   typedef enum logic [0:0] {
      S_BLANK,
      S_DRIVE
   } seg7_state_e;

endpackage

// File: rtl/seg7_hex_font.sv
// Combinational hex nibble plus decimal point to active-low segment code.
module seg7_hex_font
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   output logic [7:0] seg
);

   // Look up the glyph, then light the decimal point if requested
   always_comb begin
      seg = SEG_FONT[nibble];
      if (dp) begin
         seg[SEG_DP] = 1'b0;
      end
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with blanking gaps, per-digit enable
// and double-buffered content that is only swapped at frame boundaries.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned DIV_CNT    = 25000,
   parameter int unsigned BLANK_CYC  = 64,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    update,
   output logic                    update_ack,
   output logic                    frame_start,
   output logic [NUM_DIGITS-1:0]   sseg_an,
   output logic [7:0]              sseg_ca
);

   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned DW = (DIV_CNT > 1)    ? $clog2(DIV_CNT)    : 1;
   localparam int unsigned BW = (BLANK_CYC > 1)  ? $clog2(BLANK_CYC)  : 1;

   localparam logic [IW-1:0] IdxLast   = IW'(NUM_DIGITS - 1);
   localparam logic [DW-1:0] DivLast   = DW'(DIV_CNT - 1);
   localparam logic [BW-1:0] BlankLast = (BLANK_CYC == 0) ? '0 : BW'(BLANK_CYC - 1);

   // Without a gap the blank state would have to last zero cycles, so start driving directly
   localparam seg7_state_e StartState = (BLANK_CYC == 0) ? S_DRIVE : S_BLANK;
   localparam seg7_state_e AfterDrive = (BLANK_CYC == 0) ? S_DRIVE : S_BLANK;

   seg7_state_e state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic [BW-1:0] blank_cnt_q, blank_cnt_d;
   logic          pending_q, pending_d;

   logic [NUM_DIGITS-1:0][3:0] shadow_val_q, shadow_val_d;
   logic [NUM_DIGITS-1:0]      shadow_dp_q, shadow_dp_d;
   logic [NUM_DIGITS-1:0]      shadow_en_q, shadow_en_d;

   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [7:0]            ca_q, ca_d;
   logic                  ack_q, ack_d;
   logic                  fs_q, fs_d;

   logic                  wrap;
   logic [3:0]            font_nib;
   logic                  font_dp;
   logic [7:0]            font_seg;
   logic [NUM_DIGITS-1:0] an_lo;
   logic [7:0]            ca_lo;

   // Next-state logic: dwell/blank counters, digit index, update handshake
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      div_cnt_d    = div_cnt_q;
      blank_cnt_d  = blank_cnt_q;
      pending_d    = pending_q;
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      shadow_en_d  = shadow_en_q;
      ack_d        = 1'b0;
      fs_d         = 1'b0;
      wrap         = 1'b0;

      unique case (state_q)
         S_BLANK: begin
            if (blank_cnt_q == BlankLast) begin
               blank_cnt_d = '0;
               state_d     = S_DRIVE;
            end else begin
               blank_cnt_d = blank_cnt_q + BW'(1);
            end
         end
         S_DRIVE: begin
            if (div_cnt_q == DivLast) begin
               div_cnt_d = '0;
               state_d   = AfterDrive;
               if (idx_q == '0) begin
                  idx_d = IdxLast;
                  wrap  = 1'b1;
               end else begin
                  idx_d = idx_q - IW'(1);
               end
            end else begin
               div_cnt_d = div_cnt_q + DW'(1);
            end
         end
         default: state_d = StartState;
      endcase

      // A request on the boundary cycle itself is served on that same edge
      if (wrap) begin
         fs_d = 1'b1;
         if (pending_q || update) begin
            shadow_val_d = value;
            shadow_dp_d  = dp;
            shadow_en_d  = digit_en;
            pending_d    = 1'b0;
            ack_d        = 1'b1;
         end
      end else if (update) begin
         pending_d = 1'b1;
      end
   end

   // Outputs are decoded from the next state so the pins line up with the registered state
   assign font_nib = shadow_val_d[idx_d];
   assign font_dp  = shadow_dp_d[idx_d];

   seg7_hex_font u_font (
      .nibble (font_nib),
      .dp     (font_dp),
      .seg    (font_seg)
   );

   // Build active-low anode/segment codes, then apply output polarity
   always_comb begin
      an_lo = '1;
      ca_lo = 8'hFF;
      if (state_d == S_DRIVE) begin
         ca_lo = font_seg;
         if (shadow_en_d[idx_d]) begin
            an_lo[idx_d] = 1'b0;
         end
      end
      an_d = ACTIVE_LOW ? an_lo : ~an_lo;
      ca_d = ACTIVE_LOW ? ca_lo : ~ca_lo;
   end

   // State, shadow and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StartState;
         idx_q        <= IdxLast;
         div_cnt_q    <= '0;
         blank_cnt_q  <= '0;
         pending_q    <= 1'b0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         shadow_en_q  <= '0;
         an_q         <= ACTIVE_LOW ? '1 : '0;
         ca_q         <= ACTIVE_LOW ? 8'hFF : 8'h00;
         ack_q        <= 1'b0;
         fs_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         div_cnt_q    <= div_cnt_d;
         blank_cnt_q  <= blank_cnt_d;
         pending_q    <= pending_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         shadow_en_q  <= shadow_en_d;
         an_q         <= an_d;
         ca_q         <= ca_d;
         ack_q        <= ack_d;
         fs_q         <= fs_d;
      end
   end

   assign sseg_an     = an_q;
   assign sseg_ca     = ca_q;
   assign update_ack  = ack_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl (8 digits, dwell 4, gap 2): expected frames are
// queued when stimulus is applied and compared cycle by cycle by a monitor.
module tb_seg7_scan_ctrl;

   localparam int unsigned FRAME = 48;

   logic        clk;
   logic        rst;
   logic [31:0] value;
   logic [7:0]  dp;
   logic [7:0]  digit_en;
   logic        update;
   logic        update_ack;
   logic        frame_start;
   logic [7:0]  sseg_an;
   logic [7:0]  sseg_ca;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] an;
      logic [7:0] ca;
      logic       ack;
      logic       fs;
   } exp_t;

   exp_t sb[$];

   logic [7:0] font_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                 8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

   seg7_scan_ctrl #(
      .NUM_DIGITS (8),
      .DIV_CNT    (4),
      .BLANK_CYC  (2),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .value       (value),
      .dp          (dp),
      .digit_en    (digit_en),
      .update      (update),
      .update_ack  (update_ack),
      .frame_start (frame_start),
      .sseg_an     (sseg_an),
      .sseg_ca     (sseg_ca)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Queue one full frame of expected pin values, starting at the boundary cycle
   function automatic void push_frame(input logic [31:0] val, input logic [7:0] d,
                                      input logic [7:0] en, input logic fs0, input logic ack0);
      exp_t e;
      logic [7:0] one;
      one = 8'h01;
      for (int dg = 7; dg >= 0; dg--) begin
         for (int c = 0; c < 6; c++) begin
            e.fs  = (dg == 7 && c == 0) ? fs0 : 1'b0;
            e.ack = (dg == 7 && c == 0) ? ack0 : 1'b0;
            if (c < 2) begin
               e.an = 8'hFF;
               e.ca = 8'hFF;
            end else begin
               e.an = en[dg] ? ~(one << dg) : 8'hFF;
               e.ca = font_tab[val[4*dg +: 4]] & ~{7'b0, d[dg]};
            end
            sb.push_back(e);
         end
      end
   endfunction

   // Scoreboard monitor: compare each queued entry mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (sseg_an !== e.an) begin
            errors++;
            $display("FAIL sb_an t=%0t got %h exp %h", $time, sseg_an, e.an);
         end
         checks++;
         if (sseg_ca !== e.ca) begin
            errors++;
            $display("FAIL sb_ca t=%0t got %h exp %h", $time, sseg_ca, e.ca);
         end
         checks++;
         if (update_ack !== e.ack) begin
            errors++;
            $display("FAIL sb_ack t=%0t got %b exp %b", $time, update_ack, e.ack);
         end
         checks++;
         if (frame_start !== e.fs) begin
            errors++;
            $display("FAIL sb_fs t=%0t got %b exp %b", $time, frame_start, e.fs);
         end
      end
   end

   // Advance one frame, pulsing update at cycle upd_at (-1 = never)
   task automatic run_frame(input int upd_at);
      for (int k = 0; k < FRAME; k++) begin
         update = (k == upd_at);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      update = 1'b0;
      value = '0;
      dp = '0;
      digit_en = '0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (sseg_an !== 8'hFF) begin
         errors++;
         $display("FAIL reset_an got %h exp ff", sseg_an);
      end
      checks++;
      if (sseg_ca !== 8'hFF) begin
         errors++;
         $display("FAIL reset_ca got %h exp ff", sseg_ca);
      end
      checks++;
      if (update_ack !== 1'b0) begin
         errors++;
         $display("FAIL reset_ack got %b exp 0", update_ack);
      end
      checks++;
      if (frame_start !== 1'b0) begin
         errors++;
         $display("FAIL reset_fs got %b exp 0", frame_start);
      end
   endtask

   task automatic test_first_load();
      int n;
      bit seen;
      seen = 1'b0;
      rst = 1'b0;
      value = 32'h0123_4567;
      dp = 8'h00;
      digit_en = 8'hFF;
      update = 1'b1;
      for (n = 1; n <= 200; n++) begin
         @(posedge clk);
         #1;
         update = 1'b0;
         if (update_ack === 1'b1) begin
            seen = 1'b1;
            break;
         end
         checks++;
         if (sseg_an !== 8'hFF) begin
            errors++;
            $display("FAIL dark_before_load cycle %0d an %h exp ff", n, sseg_an);
         end
      end
      checks++;
      if (!seen || n != 48) begin
         errors++;
         $display("FAIL first_ack_latency got %0d (seen %b) exp 48", n, seen);
      end
      checks++;
      if (frame_start !== 1'b1) begin
         errors++;
         $display("FAIL first_ack_fs got %b exp 1", frame_start);
      end
      push_frame(value, dp, digit_en, 1'b1, 1'b1);
      run_frame(-1);
   endtask

   task automatic test_digit_en();
      push_frame(value, dp, digit_en, 1'b1, 1'b0);
      digit_en = 8'h0F;
      run_frame(10);
      push_frame(value, dp, digit_en, 1'b1, 1'b1);
      run_frame(-1);
   endtask

   task automatic test_mid_update();
      push_frame(value, dp, digit_en, 1'b1, 1'b0);
      value = 32'hFFFF_FFFF;
      digit_en = 8'hFF;
      run_frame(20);
      push_frame(value, dp, digit_en, 1'b1, 1'b1);
      run_frame(-1);
   endtask

   task automatic test_boundary_update();
      push_frame(value, dp, digit_en, 1'b1, 1'b0);
      value = 32'h8765_4321;
      run_frame(47);
      checks++;
      if (update_ack !== 1'b1 || frame_start !== 1'b1) begin
         errors++;
         $display("FAIL boundary_ack got ack %b fs %b exp 1 1", update_ack, frame_start);
      end
      push_frame(value, dp, digit_en, 1'b1, 1'b1);
      run_frame(-1);
      // One request, one ack: the following boundary must stay quiet
      push_frame(value, dp, digit_en, 1'b1, 1'b0);
      run_frame(-1);
   endtask

   task automatic test_dp();
      push_frame(value, dp, digit_en, 1'b1, 1'b0);
      dp = 8'h01;
      run_frame(5);
      push_frame(value, dp, digit_en, 1'b1, 1'b1);
      run_frame(-1);
   endtask

   task automatic test_rst_mid();
      push_frame(value, dp, digit_en, 1'b1, 1'b0);
      value = 32'h1111_1111;
      dp = 8'h00;
      // Cycle 15 of the frame is inside the digit 5 dwell
      for (int k = 0; k < 16; k++) begin
         update = (k == 1);
         if (k == 15) rst = 1'b1;
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      sb.delete();
      checks++;
      if (sseg_an !== 8'hFF || sseg_ca !== 8'hFF) begin
         errors++;
         $display("FAIL rst_mid_idle got an %h ca %h exp ff ff", sseg_an, sseg_ca);
      end
      // Shadows cleared: dark anodes, blank/zero-glyph pattern from digit 7 onward
      push_frame(32'h0, 8'h00, 8'h00, 1'b0, 1'b0);
      run_frame(-1);
      checks++;
      if (frame_start !== 1'b1 || update_ack !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_boundary got fs %b ack %b exp 1 0", frame_start, update_ack);
      end
   endtask

   initial begin
      test_reset();
      test_first_load();
      test_digit_en();
      test_mid_update();
      test_boundary_update();
      test_dp();
      test_rst_mid();
      @(negedge clk);
      sb.delete();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
